// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: shares one memory port between instruction fetch
// and the load/store unit, with a fetch starvation guard and a CSWAP lock.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lsu_read,
    input  logic        lsu_write,
    input  logic        lsu_lock,
    input  logic [63:0] lsu_address,
    input  logic [1:0]  lsu_datasize,
    input  logic [63:0] lsu_writedata,
    output logic [63:0] lsu_readdata,
    output logic        lsu_done,
    input  logic        if_read,
    input  logic [63:0] if_address,
    output logic [63:0] if_readdata,
    output logic        if_done,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LSU,
        S_IFU,
        S_DRAIN
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    logic        relatch;
    logic [3:0]  starve_cnt;
    logic [63:0] lsu_rd_q;
    logic [63:0] if_rd_q;

    logic lsu_req;
    logic busy;
    logic lsu_win;
    logic if_win;
    logic lsu_grant;
    logic if_grant;

    assign lsu_req = lsu_read | lsu_write;
    assign busy    = mem_read | mem_write;
    assign lsu_win = lsu_req & (~if_read | (starve_cnt != LIMIT));
    assign if_win  = if_read & ~lsu_win;

    // A locked LSU completion parks in S_LSU so fetch cannot slip in.
    assign lsu_grant = ((state == S_IDLE) & lsu_win)
                     | ((state == S_LSU) & relatch & lsu_req);
    assign if_grant  = (state == S_IDLE) & if_win;

    assign lsu_done = (state == S_LSU) & busy & mem_done;
    assign if_done  = (state == S_IFU) & busy & mem_done;

    assign lsu_readdata = lsu_done ? mem_readdata : lsu_rd_q;
    assign if_readdata  = if_done ? mem_readdata : if_rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            relatch       <= 1'b0;
            starve_cnt    <= '0;
            mem_address   <= '0;
            mem_datasize  <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            lsu_rd_q      <= '0;
            if_rd_q       <= '0;
        end else begin
            if (lsu_done) lsu_rd_q <= mem_readdata;
            if (if_done) if_rd_q <= mem_readdata;

            if (!if_read || if_grant) begin
                starve_cnt <= '0;
            end else if (lsu_grant && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            unique case (state)
                S_IDLE: begin
                    if (lsu_win) state <= S_LSU;
                    else if (if_win) state <= S_IFU;
                end
                S_LSU: begin
                    if (relatch) begin
                        if (lsu_req) begin
                            relatch <= 1'b0;
                        end else if (!lsu_lock) begin
                            relatch <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else if (mem_done) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (lsu_lock) relatch <= 1'b1;
                        else state <= S_IDLE;
                    end else if (!lsu_req) begin
                        state <= S_DRAIN;
                    end
                end
                S_IFU: begin
                    if (mem_done) begin
                        mem_read <= 1'b0;
                        state    <= S_IDLE;
                    end else if (!if_read) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mem_done) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Read wins over write when the LSU raises both.
            if (lsu_grant) begin
                mem_address   <= lsu_address;
                mem_datasize  <= lsu_datasize;
                mem_writedata <= lsu_writedata;
                mem_read      <= lsu_read;
                mem_write     <= lsu_write & ~lsu_read;
            end else if (if_grant) begin
                mem_address   <= if_address;
                mem_datasize  <= 2'd3;
                mem_writedata <= '0;
                mem_read      <= 1'b1;
                mem_write     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, grant/done scoreboard,
// vector table plus lock, starvation, abandon and reset sequences.
module tb_mem_port_arbiter;

    localparam int SL = 4;

    logic        clk;
    logic        reset_n;
    logic        lsu_read;
    logic        lsu_write;
    logic        lsu_lock;
    logic [63:0] lsu_address;
    logic [1:0]  lsu_datasize;
    logic [63:0] lsu_writedata;
    logic [63:0] lsu_readdata;
    logic        lsu_done;
    logic        if_read;
    logic [63:0] if_address;
    logic [63:0] if_readdata;
    logic        if_done;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        mem_done;

    mem_port_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .lsu_read(lsu_read),
        .lsu_write(lsu_write),
        .lsu_lock(lsu_lock),
        .lsu_address(lsu_address),
        .lsu_datasize(lsu_datasize),
        .lsu_writedata(lsu_writedata),
        .lsu_readdata(lsu_readdata),
        .lsu_done(lsu_done),
        .if_read(if_read),
        .if_address(if_address),
        .if_readdata(if_readdata),
        .if_done(if_done),
        .mem_address(mem_address),
        .mem_datasize(mem_datasize),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .mem_done(mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] a;
        logic [1:0]  sz;
        logic        wr;
        logic [63:0] wd;
    } gnt_t;

    gnt_t        gq[$];
    logic [63:0] lq[$];
    logic [63:0] iq[$];

    typedef struct {
        logic        lrd;
        logic        lwr;
        logic [63:0] la;
        logic [1:0]  ls;
        logic [63:0] lwd;
        logic        ird;
        logic [63:0] ia;
        logic        lk;
        int          lat;
        logic        exp_wr;
        logic        lsu_first;
    } vec_t;

    vec_t vt[7];

    function automatic logic [63:0] rd_of(input logic [63:0] a);
        if (a == 64'h100) return 64'hDEAD_BEEF;
        return {~a[31:0], a[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_gnt(input logic [63:0] a, input logic [1:0] sz,
                            input logic wr, input logic [63:0] wd);
        gnt_t g;
        g.a = a;
        g.sz = sz;
        g.wr = wr;
        g.wd = wd;
        gq.push_back(g);
    endtask

    task automatic push_lsu(input logic [63:0] a, input logic [1:0] sz,
                            input logic wr, input logic [63:0] wd);
        push_gnt(a, sz, wr, wd);
        lq.push_back(rd_of(a));
    endtask

    task automatic push_ifu(input logic [63:0] a);
        push_gnt(a, 2'd3, 1'b0, 64'h0);
        iq.push_back(rd_of(a));
    endtask

    // Memory model: answers mem_lat cycles after the strobe rises.
    int mem_lat = 2;
    int mcnt = 0;
    always @(posedge clk) begin
        #1;
        if (!reset_n || mem_done) begin
            mem_done = 1'b0;
            mcnt = 0;
        end else if (mem_read || mem_write) begin
            mcnt++;
            if (mcnt >= mem_lat) begin
                mem_done = 1'b1;
                mem_readdata = rd_of(mem_address);
            end
        end else begin
            mcnt = 0;
        end
    end

    logic strobe_q = 1'b0;
    logic strobe_n;
    gnt_t gm;
    logic [63:0] dm;

    always @(negedge clk) begin
        strobe_n = mem_read | mem_write;
        if (strobe_n && !strobe_q) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexp_grant: got addr %h, expected no grant",
                         mem_address);
            end else begin
                gm = gq.pop_front();
                chk("gnt_addr", mem_address, gm.a);
                chk("gnt_size", 64'(mem_datasize), 64'(gm.sz));
                chk("gnt_write", 64'(mem_write), 64'(gm.wr));
                chk("gnt_read", 64'(mem_read), 64'(!gm.wr));
                if (gm.wr) chk("gnt_wdata", mem_writedata, gm.wd);
            end
        end
        strobe_q = strobe_n;
        if (lsu_done) begin
            if (lq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexp_lsu_done: got 1 expected 0");
            end else begin
                dm = lq.pop_front();
                chk("lsu_rdata", lsu_readdata, dm);
            end
        end
        if (if_done) begin
            if (iq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexp_if_done: got 1 expected 0");
            end else begin
                dm = iq.pop_front();
                chk("if_rdata", if_readdata, dm);
            end
        end
        if (lsu_done && if_done) begin
            checks++;
            errors++;
            $display("FAIL both_done: got 1 expected 0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu_txn(input logic rd, input logic wr,
                           input logic [63:0] a, input logic [1:0] sz,
                           input logic [63:0] wd, input logic lk);
        bit seen;
        seen = 1'b0;
        lsu_read = rd;
        lsu_write = wr;
        lsu_address = a;
        lsu_datasize = sz;
        lsu_writedata = wd;
        lsu_lock = lk;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (lsu_done) seen = 1'b1;
        end
        if (!seen) chk("lsu_timeout", 64'(seen), 64'd1);
        tick();
        lsu_read = 1'b0;
        lsu_write = 1'b0;
    endtask

    task automatic ifu_txn(input logic [63:0] a);
        bit seen;
        seen = 1'b0;
        if_read = 1'b1;
        if_address = a;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (if_done) seen = 1'b1;
        end
        if (!seen) chk("ifu_timeout", 64'(seen), 64'd1);
        tick();
        if_read = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic has_l;
        has_l = v.lrd | v.lwr;
        mem_lat = v.lat;
        lsu_lock = v.lk;
        if (has_l && v.ird && !v.lsu_first) push_ifu(v.ia);
        if (has_l) push_lsu(v.la, v.ls, v.exp_wr, v.lwd);
        if (v.ird && (!has_l || v.lsu_first)) push_ifu(v.ia);
        fork
            if (has_l) lsu_txn(v.lrd, v.lwr, v.la, v.ls, v.lwd, v.lk);
            if (v.ird) ifu_txn(v.ia);
        join
        lsu_lock = 1'b0;
        repeat (2) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
        chk({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        chk({tag, "_mem_addr"}, mem_address, 64'd0);
        chk({tag, "_mem_size"}, 64'(mem_datasize), 64'd0);
        chk({tag, "_mem_wdata"}, mem_writedata, 64'd0);
        chk({tag, "_lsu_done"}, 64'(lsu_done), 64'd0);
        chk({tag, "_if_done"}, 64'(if_done), 64'd0);
        chk({tag, "_lsu_rdata"}, lsu_readdata, 64'd0);
        chk({tag, "_if_rdata"}, if_readdata, 64'd0);
    endtask

    initial begin
        bit seen;

        vt[0] = '{1, 0, 64'h100, 2'd2, 64'h0, 0, 64'h0, 0, 3, 0, 1};
        vt[1] = '{0, 1, 64'h208, 2'd0, 64'h55, 1, 64'h1000, 0, 2, 1, 1};
        vt[2] = '{0, 0, 64'h0, 2'd0, 64'h0, 1, 64'h2000, 0, 1, 0, 1};
        vt[3] = '{1, 1, 64'h300, 2'd1, 64'h77, 0, 64'h0, 0, 2, 0, 1};
        vt[4] = '{0, 0, 64'h0, 2'd0, 64'h0, 1, 64'h2100, 1, 3, 0, 1};
        vt[5] = '{0, 1, 64'h318, 2'd3, 64'h0123_4567_89AB_CDEF,
                  1, 64'h3000, 0, 1, 1, 1};
        vt[6] = '{1, 0, 64'h320, 2'd3, 64'h0, 1, 64'h3100, 0, 5, 0, 1};

        reset_n = 1'b0;
        lsu_read = 1'b0;
        lsu_write = 1'b0;
        lsu_lock = 1'b0;
        lsu_address = '0;
        lsu_datasize = '0;
        lsu_writedata = '0;
        if_read = 1'b0;
        if_address = '0;
        mem_readdata = '0;
        mem_done = 1'b0;

        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset_n = 1'b1;
        tick();

        // One-cycle arbitration latency on a plain LSU read.
        mem_lat = 3;
        push_lsu(64'h100, 2'd2, 1'b0, 64'h0);
        lsu_read = 1'b1;
        lsu_address = 64'h100;
        lsu_datasize = 2'd2;
        @(negedge clk);
        chk("lat_first_cycle", 64'(mem_read), 64'd0);
        @(negedge clk);
        chk("lat_strobe", 64'(mem_read), 64'd1);
        chk("lat_size", 64'(mem_datasize), 64'd2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (lsu_done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rd_done_seen", 64'(seen), 64'd1);
        chk("rd_if_done", 64'(if_done), 64'd0);
        chk("rd_data", lsu_readdata, 64'hDEAD_BEEF);
        tick();
        lsu_read = 1'b0;
        @(negedge clk);
        chk("rd_strobe_drop", 64'(mem_read), 64'd0);
        chk("rd_data_hold", lsu_readdata, 64'hDEAD_BEEF);
        tick();

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Starvation: four LSU grants, then fetch is forced in.
        mem_lat = 1;
        for (int k = 0; k < SL; k++) push_lsu(64'h400 + 64'(8 * k), 2'd3, 1'b0, 64'h0);
        push_ifu(64'h5000);
        for (int k = SL; k < 6; k++) push_lsu(64'h400 + 64'(8 * k), 2'd3, 1'b0, 64'h0);
        fork
            ifu_txn(64'h5000);
            begin
                for (int k = 0; k < 6; k++)
                    lsu_txn(1'b1, 1'b0, 64'h400 + 64'(8 * k), 2'd3, 64'h0, 1'b0);
            end
        join
        repeat (2) tick();

        // Counter starts over: LSU wins the next contested grant.
        push_lsu(64'h480, 2'd3, 1'b0, 64'h0);
        push_ifu(64'h5100);
        fork
            ifu_txn(64'h5100);
            lsu_txn(1'b1, 1'b0, 64'h480, 2'd3, 64'h0, 1'b0);
        join
        repeat (2) tick();

        // CSWAP: locked read then write, fetch waits behind both.
        mem_lat = 2;
        push_lsu(64'h600, 2'd3, 1'b0, 64'h0);
        push_lsu(64'h600, 2'd3, 1'b1, 64'hCAFE_F00D);
        push_ifu(64'h6000);
        fork
            ifu_txn(64'h6000);
            begin
                lsu_txn(1'b1, 1'b0, 64'h600, 2'd3, 64'h0, 1'b1);
                lsu_txn(1'b0, 1'b1, 64'h600, 2'd3, 64'hCAFE_F00D, 1'b0);
            end
        join
        lsu_lock = 1'b0;
        repeat (2) tick();

        // Fetch abandons its grant: strobe drains, no done.
        mem_lat = 4;
        push_gnt(64'h4000, 2'd3, 1'b0, 64'h0);
        if_read = 1'b1;
        if_address = 64'h4000;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_read) seen = 1'b1;
        end
        chk("drain_grant", 64'(seen), 64'd1);
        tick();
        if_read = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_done) seen = 1'b1;
            else chk("drain_hold", 64'(mem_read), 64'd1);
        end
        chk("drain_done_seen", 64'(seen), 64'd1);
        chk("drain_if_done", 64'(if_done), 64'd0);
        @(negedge clk);
        chk("drain_idle", 64'(mem_read), 64'd0);
        tick();

        // Reset in the middle of an LSU read.
        mem_lat = 20;
        push_gnt(64'h700, 2'd1, 1'b0, 64'h0);
        lsu_read = 1'b1;
        lsu_address = 64'h700;
        lsu_datasize = 2'd1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_read) seen = 1'b1;
        end
        chk("mid_grant", 64'(seen), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        lsu_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(mem_read | mem_write), 64'd0);
        end

        chk("gq_empty", 64'(gq.size()), 64'd0);
        chk("lq_empty", 64'(lq.size()), 64'd0);
        chk("iq_empty", 64'(iq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch unit (IFU, read-only, octa) and the exec_unit load/store path (LSU: byte/wyde/tetra/octa reads and writes).
- Sits between exec_unit/fetch and the memory controller.
- Latches the winning request, holds the downstream strobe until mem_done, and routes readdata/done back to the winner.
- Provides starvation protection for fetch and an atomic lock so CSWAP read-then-write cannot be split.

Parameters:
STARVE_LIMIT, 4, consecutive LSU grants while IFU waits before IFU is forced to win (1..15)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
lsu_read  in  1  LSU read request, level, held until lsu_done
lsu_write  in  1  LSU write request, level, held until lsu_done
lsu_lock  in  1  LSU atomic-sequence hold (CSWAP)
lsu_address  in  64  LSU byte address
lsu_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
lsu_writedata  in  64  LSU store data
lsu_readdata  out  64  read data to LSU
lsu_done  out  1  one-cycle completion pulse to LSU
if_read  in  1  IFU fetch request, level, held until if_done
if_address  in  64  fetch address
if_readdata  out  64  read data to IFU
if_done  out  1  one-cycle completion pulse to IFU
mem_address  out  64  downstream address
mem_datasize  out  2  downstream size
mem_read  out  1  downstream read strobe
mem_write  out  1  downstream write strobe
mem_writedata  out  64  downstream write data
mem_readdata  in  64  downstream read data, valid with mem_done
mem_done  in  1  downstream one-cycle completion

Behaviour:
- Reset: state S_IDLE; all outputs 0; starve counter 0; latched request registers 0. Reset mid-transaction drops the transaction immediately; no done pulse is issued.
- States:
  - S_IDLE: no grant.
  - S_LSU: LSU granted.
  - S_IFU: IFU granted.
  - S_DRAIN: requester abandoned; waiting for mem_done.
- S_IDLE arbitration, sampled on the clock edge:
  - LSU request = lsu_read | lsu_write.
  - If only one requester is active, it wins.
  - If both are active, LSU wins unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
  - On grant, address, size, write data and read/write kind are latched. The downstream strobe asserts in the cycle after the request is first seen: one cycle of arbitration latency.
- LSU read/write conflict: if lsu_read and lsu_write are both 1 at grant, the read is taken and the write is ignored.
- IFU grants always use datasize 3 and read only.
- In a grant state, the mem_* outputs come from the latched registers. The strobe is held until mem_done.
- On mem_done:
  - mem_readdata is forwarded combinationally to the winner's readdata.
  - The winner's done pulses in the same cycle.
  - The non-winner's done stays 0.
  - readdata outputs are otherwise held at their last value.
- After mem_done: next state is S_IDLE, so the strobe deasserts for at least one cycle. Exception: S_LSU with lsu_lock=1 goes to S_LSU_RELATCH behaviour, meaning it stays in S_LSU and relatches the LSU request on the next cycle in which LSU requests. IFU cannot win while the lock is held after an LSU completion.
- lsu_lock is honoured only on an LSU completion; lock=1 in S_IDLE has no effect.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each LSU grant while if_read=1.
  - Cleared on an IFU grant, or on any cycle with if_read=0.
- Abandon: if the granted requester drops its request before mem_done (pipeline flush), go to S_DRAIN. The strobe is held until mem_done, no done pulse is issued, then go to S_IDLE.
- mem_done while in S_IDLE is ignored.

Test Plan:
- LSU read, lsu_address=0x100, size 2, memory answers after 3 cycles with 0xDEADBEEF → mem_read=1 one cycle after request, mem_datasize=2; lsu_done pulses with lsu_readdata=0xDEADBEEF; if_done stays 0.
- Simultaneous if_read and lsu_write (writedata=0x55) → LSU granted first (mem_write=1, mem_writedata=0x55); IFU granted after one idle cycle.
- LSU back-to-back requests with if_read held, STARVE_LIMIT=4 → exactly 4 LSU grants, then IFU grant with mem_datasize=3; counter resets afterwards.
- CSWAP: lsu_read with lsu_lock=1, done, then lsu_write, while if_read is pending → write is granted to LSU before IFU, with no IFU grant in between.
- IFU drops if_read after grant, mem_done arrives 2 cycles later → mem_read held until mem_done, if_done never pulses, returns to S_IDLE.
- reset_n asserted while mem_read=1 → all outputs 0 asynchronously; after release the arbiter is idle with no stale done pulse.
